// File: rtl/apb_bus_bridge.sv
// apb_bus_bridge: address-decoded bridge from the RV32I data port to NUM_SLAVES APB4 slaves.
// Latency: ready 3 cycles after req is sampled for a zero-wait slave (+1 per wait cycle); decode errors answer in 1.
// Backpressure: core holds req until ready; slaves stall with PREADY, bounded by TIMEOUT ACCESS cycles.
//
// Ports: clk/reset (async active-low); core side req/busWe/busAddr/busWData/strb in,
// busRData/ready/err out; APB side PADDR/PWDATA/PWRITE/PSTRB/PSEL/PENABLE out,
// PRDATA/PREADY/PSLVERR in (one lane/bit per slave).
module apb_bus_bridge #(
    parameter int          NUM_SLAVES  = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          REGION_BITS = 12,
    parameter int          TIMEOUT     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     busWe,
    input  logic [31:0]              busAddr,
    input  logic [31:0]              busWData,
    input  logic [2:0]               strb,
    output logic [31:0]              busRData,
    output logic                     ready,
    output logic                     err,
    output logic [REGION_BITS-1:0]   PADDR,
    output logic [31:0]              PWDATA,
    output logic                     PWRITE,
    output logic [3:0]               PSTRB,
    output logic [NUM_SLAVES-1:0]    PSEL,
    output logic                     PENABLE,
    input  logic [NUM_SLAVES*32-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY,
    input  logic [NUM_SLAVES-1:0]    PSLVERR
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // One past the last mapped byte; 33 bits so a window ending at 4 GiB does not wrap.
    localparam logic [32:0] WINDOW_END = {1'b0, BASE_ADDR} + (33'(NUM_SLAVES) << REGION_BITS);

    logic [1:0]       state;
    logic [IDX_W-1:0] slaveIdx;
    logic [CNT_W-1:0] accessCnt;

    logic [31:0]      addrOffset;
    logic [IDX_W-1:0] reqIdx;
    logic             mapped;
    logic             sizeBad;
    logic             misaligned;
    logic             reqBad;
    logic [3:0]       reqStrb;
    logic [31:0]      reqWData;

    // Request decode, only consumed in IDLE.
    always_comb begin
        addrOffset = busAddr - BASE_ADDR;
        reqIdx     = IDX_W'(addrOffset >> REGION_BITS);
        mapped     = (busAddr >= BASE_ADDR) && ({1'b0, busAddr} < WINDOW_END);
        // strb[2] only marks unsigned loads; 011, 110 and 111 have no size.
        sizeBad    = (strb[1:0] == 2'b11) || (strb[2:1] == 2'b11);
        misaligned = ((strb[1:0] == 2'b01) && busAddr[0]) ||
                     ((strb[1:0] == 2'b10) && (busAddr[1:0] != 2'b00));
        reqBad     = sizeBad || !mapped || misaligned;

        reqStrb  = 4'b0000;
        reqWData = 32'h0;
        if (busWe) begin
            case (strb[1:0])
                2'b00: begin
                    reqStrb  = 4'b0001 << busAddr[1:0];
                    reqWData = {4{busWData[7:0]}};
                end
                2'b01: begin
                    reqStrb  = busAddr[1] ? 4'b1100 : 4'b0011;
                    reqWData = {2{busWData[15:0]}};
                end
                default: begin
                    reqStrb  = 4'b1111;
                    reqWData = busWData;
                end
            endcase
        end
    end

    logic [31:0] slaveRData [NUM_SLAVES];
    for (genvar g = 0; g < NUM_SLAVES; g++) begin : gRData
        assign slaveRData[g] = PRDATA[32*g +: 32];
    end

    logic        selReady;
    logic        selErr;
    logic [31:0] selRData;
    assign selReady = PREADY[slaveIdx];
    assign selErr   = PSLVERR[slaveIdx];
    assign selRData = slaveRData[slaveIdx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            slaveIdx  <= '0;
            accessCnt <= '0;
            busRData  <= 32'h0;
            ready     <= 1'b0;
            err       <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= 32'h0;
            PWRITE    <= 1'b0;
            PSTRB     <= 4'b0000;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    err      <= 1'b0;
                    busRData <= 32'h0;
                    if (req) begin
                        if (reqBad) begin
                            // Rejected before any slave sees it.
                            ready <= 1'b1;
                            err   <= 1'b1;
                            state <= RESP;
                        end else begin
                            // APB outputs are frozen here until the transfer ends,
                            // so later core-side changes cannot disturb the bus.
                            slaveIdx <= reqIdx;
                            PADDR    <= busAddr[REGION_BITS-1:0];
                            PWDATA   <= reqWData;
                            PWRITE   <= busWe;
                            PSTRB    <= reqStrb;
                            PSEL     <= NUM_SLAVES'(1) << reqIdx;
                            state    <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    PENABLE   <= 1'b1;
                    accessCnt <= CNT_W'(1);
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (selReady) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        ready     <= 1'b1;
                        err       <= selErr;
                        busRData  <= PWRITE ? 32'h0 : selRData;
                        accessCnt <= '0;
                        state     <= RESP;
                    end else if (accessCnt == CNT_W'(TIMEOUT)) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        ready     <= 1'b1;
                        err       <= 1'b1;
                        busRData  <= 32'h0;
                        accessCnt <= '0;
                        state     <= RESP;
                    end else begin
                        accessCnt <= accessCnt + CNT_W'(1);
                    end
                end
                default: begin
                    // RESP: the one-cycle ready pulse is on the outputs now.
                    err      <= 1'b0;
                    busRData <= 32'h0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_bus_bridge.sv
module tb_apb_bus_bridge;

    localparam int          NS   = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          RB   = 12;
    localparam int          TO   = 16;

    logic        clk;
    logic        reset;
    logic        req;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [2:0]  strb;
    logic [31:0] busRData;
    logic        ready;
    logic        err;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic [3:0]  PSTRB;
    logic [3:0]  PSEL;
    logic        PENABLE;
    logic [127:0] PRDATA;
    logic [3:0]  PREADY;
    logic [3:0]  PSLVERR;

    apb_bus_bridge #(.NUM_SLAVES(NS), .BASE_ADDR(BASE), .REGION_BITS(RB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .busWe(busWe), .busAddr(busAddr),
        .busWData(busWData), .strb(strb), .busRData(busRData), .ready(ready), .err(err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSTRB(PSTRB), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave models: wait count, read data and error flag per slave.
    int          waitCfg [NS];
    logic [31:0] dataCfg [NS];
    logic        errCfg  [NS];
    logic [3:0]  noiseReady = 4'h0;
    logic [3:0]  noiseErr = 4'h0;
    logic [31:0] noiseData [NS];
    int          accCnt = 0;

    always @(posedge clk) accCnt <= PENABLE ? accCnt + 1 : 0;

    // Unselected slaves chatter randomly; the bridge must ignore them.
    always @(negedge clk) begin
        noiseReady <= 4'($urandom);
        noiseErr   <= 4'($urandom);
        for (int s = 0; s < NS; s++) noiseData[s] <= $urandom;
    end

    always_comb begin
        PREADY  = 4'h0;
        PSLVERR = 4'h0;
        PRDATA  = '0;
        for (int s = 0; s < NS; s++) begin
            PREADY[s]          = PSEL[s] ? (PENABLE && (accCnt >= waitCfg[s])) : noiseReady[s];
            PSLVERR[s]         = PSEL[s] ? errCfg[s] : noiseErr[s];
            PRDATA[32*s +: 32] = PSEL[s] ? dataCfg[s] : noiseData[s];
        end
    end

    // Observations of one transfer.
    int          obsFirstPsel, obsPselCycles, obsPenFirst, obsPenCycles, obsRdyCycle, obsRdyCount;
    logic [3:0]  obsPsel, obsPstrb;
    logic [11:0] obsPaddr;
    logic [31:0] obsPwdata, obsRData;
    logic        obsPwrite, obsErr, obsStable;
    logic [38:0] obsPost;

    // Reference expectations.
    int          expPselCycles, expPenCycles, expRdyCycle;
    logic [3:0]  expPsel, expPstrb;
    logic [11:0] expPaddr;
    logic [31:0] expPwdata, expRData;
    logic        expPwrite, expErr;

    // Called just after a negedge with the bridge idle. Cycle k = the k-th negedge after the request.
    task automatic runTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size);
        obsFirstPsel = 0; obsPselCycles = 0; obsPenFirst = 0; obsPenCycles = 0;
        obsRdyCycle = 0; obsRdyCount = 0; obsStable = 1'b1; obsErr = 1'b0; obsRData = 32'h0;
        obsPsel = 4'h0; obsPstrb = 4'h0; obsPaddr = 12'h0; obsPwdata = 32'h0; obsPwrite = 1'b0;
        obsPost = '1;
        req = 1'b1; busWe = we; busAddr = addr; busWData = wdata; strb = size;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (PSEL != 4'h0) begin
                if (obsPselCycles == 0) begin
                    obsFirstPsel = k; obsPsel = PSEL; obsPaddr = PADDR; obsPstrb = PSTRB;
                    obsPwdata = PWDATA; obsPwrite = PWRITE;
                end else if ({PSEL, PADDR, PSTRB, PWDATA, PWRITE} !==
                             {obsPsel, obsPaddr, obsPstrb, obsPwdata, obsPwrite}) begin
                    obsStable = 1'b0;
                end
                obsPselCycles++;
            end
            if (PENABLE) begin
                if (obsPenCycles == 0) obsPenFirst = k;
                obsPenCycles++;
            end
            if (ready) begin
                obsRdyCount++;
                if (obsRdyCycle == 0) begin
                    obsRdyCycle = k; obsErr = err; obsRData = busRData;
                end
            end
            if (k == 1) begin
                // Drop req and scramble the core side; the transfer must not notice.
                req = 1'b0; busWe = 1'($urandom); busAddr = $urandom;
                busWData = $urandom; strb = 3'($urandom);
            end
            if (obsRdyCycle != 0 && k == obsRdyCycle + 1) begin
                obsPost = {ready, err, busRData, PSEL, PENABLE};
                break;
            end
        end
    endtask

    // Expected outcome from the decode / APB rules, using plain arithmetic.
    task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] size);
        longint a, lo, hi, region;
        int     nbytes, slave, w, lane0;
        logic   sizeOk, mapped, aligned;
        a = longint'(addr); lo = longint'(BASE); region = longint'(1) << RB;
        hi = lo + NS * region;
        sizeOk = (size == 3'd0) || (size == 3'd1) || (size == 3'd2) || (size == 3'd4) || (size == 3'd5);
        nbytes = 1 << size[1:0];
        mapped = (a >= lo) && (a < hi);
        aligned = (a % nbytes) == 0;
        expPsel = 4'h0; expPaddr = 12'h0; expPstrb = 4'h0; expPwdata = 32'h0; expPwrite = we;
        if (!(sizeOk && mapped && aligned)) begin
            expPselCycles = 0; expPenCycles = 0; expRdyCycle = 1; expErr = 1'b1; expRData = 32'h0;
        end else begin
            slave = int'((a - lo) / region);
            expPsel = 4'(1 << slave);
            expPaddr = 12'(a % region);
            lane0 = int'(a % 4);
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (i >= lane0 && i < lane0 + nbytes) expPstrb[i] = 1'b1;
                    expPwdata[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
                end
            end
            w = waitCfg[slave];
            if (w < TO) begin
                expPenCycles = w + 1; expRdyCycle = w + 3; expErr = errCfg[slave];
                expRData = we ? 32'h0 : dataCfg[slave];
            end else begin
                expPenCycles = TO; expRdyCycle = TO + 2; expErr = 1'b1; expRData = 32'h0;
            end
            expPselCycles = expPenCycles + 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busRData, ready, err, PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE} !== '0) begin
            errors++; $display("FAIL reset_outputs got %h want 0",
                {busRData, ready, err, PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready, PSEL, PENABLE} !== '0) begin
            errors++; $display("FAIL idle_after_reset got %h want 0", {ready, PSEL, PENABLE});
        end
    endtask

    task automatic test_word_store();
        waitCfg[1] = 0; errCfg[1] = 1'b0;
        runTxn(1'b1, 32'h1000_1008, 32'hDEAD_BEEF, 3'b010);
        checks++; if (obsPsel !== 4'b0010) begin errors++; $display("FAIL ws_psel got %b want 0010", obsPsel); end
        checks++; if (obsPaddr !== 12'h008) begin errors++; $display("FAIL ws_paddr got %h want 008", obsPaddr); end
        checks++; if (obsPstrb !== 4'b1111) begin errors++; $display("FAIL ws_pstrb got %b want 1111", obsPstrb); end
        checks++; if (obsPwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws_pwdata got %h want deadbeef", obsPwdata); end
        checks++; if (obsPwrite !== 1'b1) begin errors++; $display("FAIL ws_pwrite got %b want 1", obsPwrite); end
        checks++; if (obsFirstPsel !== 1) begin errors++; $display("FAIL ws_psel_cycle got %0d want 1", obsFirstPsel); end
        checks++; if (obsPenFirst !== 2) begin errors++; $display("FAIL ws_penable_cycle got %0d want 2", obsPenFirst); end
        checks++; if (obsRdyCycle !== 3) begin errors++; $display("FAIL ws_ready_cycle got %0d want 3", obsRdyCycle); end
        checks++; if (obsErr !== 1'b0) begin errors++; $display("FAIL ws_err got %b want 0", obsErr); end
    endtask

    task automatic test_byte_half();
        waitCfg[0] = 0; errCfg[0] = 1'b0;
        runTxn(1'b1, 32'h1000_0003, 32'h0000_00A5, 3'b000);
        checks++; if (obsPstrb !== 4'b1000) begin errors++; $display("FAIL byte_pstrb got %b want 1000", obsPstrb); end
        checks++; if (obsPwdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byte_pwdata got %h want a5a5a5a5", obsPwdata); end
        runTxn(1'b1, 32'h1000_0002, 32'h1234_BEEF, 3'b001);
        checks++; if (obsPstrb !== 4'b1100) begin errors++; $display("FAIL half_pstrb got %b want 1100", obsPstrb); end
        checks++; if (obsPwdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL half_pwdata got %h want beefbeef", obsPwdata); end
    endtask

    task automatic test_wait_load();
        waitCfg[2] = 3; errCfg[2] = 1'b0; dataCfg[2] = 32'h1234_5678;
        runTxn(1'b0, 32'h1000_2010, 32'h0, 3'b010);
        checks++; if (obsPenCycles !== 4) begin errors++; $display("FAIL wl_penable_cycles got %0d want 4", obsPenCycles); end
        checks++; if (obsRdyCycle !== 6) begin errors++; $display("FAIL wl_ready_cycle got %0d want 6", obsRdyCycle); end
        checks++; if (obsRData !== 32'h1234_5678) begin errors++; $display("FAIL wl_rdata got %h want 12345678", obsRData); end
        checks++; if (obsPstrb !== 4'b0000) begin errors++; $display("FAIL wl_pstrb got %b want 0000", obsPstrb); end
        checks++; if (obsStable !== 1'b1) begin errors++; $display("FAIL wl_apb_stable got %b want 1", obsStable); end
    endtask

    task automatic test_errors();
        runTxn(1'b0, 32'h2000_0000, 32'h0, 3'b010);
        checks++; if (obsRdyCycle !== 1 || obsErr !== 1'b1) begin errors++; $display("FAIL unmapped_resp got cycle %0d err %b want 1 1", obsRdyCycle, obsErr); end
        checks++; if (obsPselCycles !== 0) begin errors++; $display("FAIL unmapped_psel got %0d cycles want 0", obsPselCycles); end
        runTxn(1'b0, 32'h1000_0002, 32'h0, 3'b010);
        checks++; if (obsRdyCycle !== 1 || obsErr !== 1'b1 || obsPselCycles !== 0) begin errors++; $display("FAIL misaligned_resp got cycle %0d err %b psel %0d want 1 1 0", obsRdyCycle, obsErr, obsPselCycles); end
        runTxn(1'b1, 32'h1000_0000, 32'h0, 3'b011);
        checks++; if (obsRdyCycle !== 1 || obsErr !== 1'b1 || obsPselCycles !== 0) begin errors++; $display("FAIL badsize_resp got cycle %0d err %b psel %0d want 1 1 0", obsRdyCycle, obsErr, obsPselCycles); end
        waitCfg[3] = 1; errCfg[3] = 1'b1;
        runTxn(1'b1, 32'h1000_3000, 32'h5555_AAAA, 3'b010);
        checks++; if (obsErr !== 1'b1 || obsRdyCycle !== 4) begin errors++; $display("FAIL pslverr got err %b cycle %0d want 1 4", obsErr, obsRdyCycle); end
        errCfg[3] = 1'b0;
    endtask

    task automatic test_timeout();
        waitCfg[0] = 100; errCfg[0] = 1'b0; dataCfg[0] = 32'hCAFE_F00D;
        runTxn(1'b0, 32'h1000_0010, 32'h0, 3'b010);
        checks++; if (obsPenCycles !== TO) begin errors++; $display("FAIL to_penable_cycles got %0d want %0d", obsPenCycles, TO); end
        checks++; if (obsRdyCycle !== TO + 2) begin errors++; $display("FAIL to_ready_cycle got %0d want %0d", obsRdyCycle, TO + 2); end
        checks++; if (obsErr !== 1'b1 || obsRData !== 32'h0) begin errors++; $display("FAIL to_resp got err %b rdata %h want 1 0", obsErr, obsRData); end
        checks++; if (obsPost !== '0) begin errors++; $display("FAIL to_post got %h want 0", obsPost); end
        waitCfg[0] = 0;
        runTxn(1'b0, 32'h1000_0010, 32'h0, 3'b010);
        checks++; if (obsRdyCycle !== 3 || obsErr !== 1'b0 || obsRData !== 32'hCAFE_F00D) begin errors++; $display("FAIL to_recover got cycle %0d err %b rdata %h want 3 0 cafef00d", obsRdyCycle, obsErr, obsRData); end
    endtask

    task automatic test_reset_mid();
        int rdySeen;
        waitCfg[1] = 100; errCfg[1] = 1'b0; dataCfg[1] = 32'h0BAD_F00D;
        req = 1'b1; busWe = 1'b0; busAddr = 32'h1000_1004; strb = 3'b010;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (PENABLE !== 1'b1) begin errors++; $display("FAIL rm_in_access got %b want 1", PENABLE); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busRData, ready, err, PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE} !== '0) begin
            errors++; $display("FAIL rm_async_clear got %h want 0",
                {busRData, ready, err, PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE});
        end
        rdySeen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ready) rdySeen++;
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ready) rdySeen++;
        end
        checks++; if (rdySeen !== 0) begin errors++; $display("FAIL rm_no_ready got %0d pulses want 0", rdySeen); end
        waitCfg[1] = 0;
        runTxn(1'b0, 32'h1000_1004, 32'h0, 3'b010);
        checks++; if (obsRdyCycle !== 3 || obsRData !== 32'h0BAD_F00D) begin errors++; $display("FAIL rm_after got cycle %0d rdata %h want 3 0badf00d", obsRdyCycle, obsRData); end
    endtask

    task automatic test_random();
        logic        we;
        logic [31:0] addr, wdata;
        logic [2:0]  size;
        int          kind, pick;
        for (int it = 0; it < 40; it++) begin
            for (int s = 0; s < NS; s++) begin
                pick = $urandom_range(0, 11);
                waitCfg[s] = (pick < 8) ? pick % 4 : 14 + (pick - 8);
                dataCfg[s] = $urandom;
                errCfg[s]  = ($urandom_range(0, 3) == 0);
            end
            we = 1'($urandom); wdata = $urandom;
            pick = $urandom_range(0, 4);
            size = (pick == 0) ? 3'd0 : (pick == 1) ? 3'd1 : (pick == 2) ? 3'd2 : (pick == 3) ? 3'd4 : 3'd5;
            kind = $urandom_range(0, 9);
            addr = BASE + 32'($urandom_range(0, NS - 1)) * 32'h1000 + 32'($urandom_range(0, 4095));
            if (kind < 5) addr = addr & ~((32'd1 << size[1:0]) - 32'd1);
            else if (kind == 6) size = 3'($urandom);
            else if (kind == 7) addr = BASE + NS * 32'h1000 + 32'($urandom_range(0, 64));
            else if (kind == 8) addr = BASE - 32'd1 - 32'($urandom_range(0, 64));
            else if (kind == 9) addr = $urandom;
            predict(we, addr, wdata, size);
            runTxn(we, addr, wdata, size);
            checks++; if (obsPselCycles !== expPselCycles) begin errors++; $display("FAIL rnd%0d_psel_cycles got %0d want %0d", it, obsPselCycles, expPselCycles); end
            checks++; if (obsPenCycles !== expPenCycles) begin errors++; $display("FAIL rnd%0d_penable_cycles got %0d want %0d", it, obsPenCycles, expPenCycles); end
            checks++; if (obsRdyCycle !== expRdyCycle) begin errors++; $display("FAIL rnd%0d_ready_cycle got %0d want %0d", it, obsRdyCycle, expRdyCycle); end
            checks++; if (obsRdyCount !== 1) begin errors++; $display("FAIL rnd%0d_ready_pulses got %0d want 1", it, obsRdyCount); end
            checks++; if (obsErr !== expErr) begin errors++; $display("FAIL rnd%0d_err got %b want %b", it, obsErr, expErr); end
            checks++; if (obsRData !== expRData) begin errors++; $display("FAIL rnd%0d_rdata got %h want %h", it, obsRData, expRData); end
            checks++; if (obsPost !== '0) begin errors++; $display("FAIL rnd%0d_post got %h want 0", it, obsPost); end
            if (expPselCycles != 0) begin
                checks++; if (obsPsel !== expPsel) begin errors++; $display("FAIL rnd%0d_psel got %b want %b", it, obsPsel, expPsel); end
                checks++; if (obsPaddr !== expPaddr) begin errors++; $display("FAIL rnd%0d_paddr got %h want %h", it, obsPaddr, expPaddr); end
                checks++; if (obsPstrb !== expPstrb) begin errors++; $display("FAIL rnd%0d_pstrb got %b want %b", it, obsPstrb, expPstrb); end
                checks++; if (obsPwdata !== expPwdata) begin errors++; $display("FAIL rnd%0d_pwdata got %h want %h", it, obsPwdata, expPwdata); end
                checks++; if (obsPwrite !== expPwrite) begin errors++; $display("FAIL rnd%0d_pwrite got %b want %b", it, obsPwrite, expPwrite); end
                checks++; if (obsStable !== 1'b1 || obsFirstPsel !== 1 || obsPenFirst !== 2) begin errors++; $display("FAIL rnd%0d_phases got stable %b psel@%0d pen@%0d want 1 1 2", it, obsStable, obsFirstPsel, obsPenFirst); end
            end
        end
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; busWe = 1'b0; busAddr = 32'h0; busWData = 32'h0; strb = 3'b010;
        for (int s = 0; s < NS; s++) begin
            waitCfg[s] = 0; dataCfg[s] = 32'h0; errCfg[s] = 1'b0;
        end
        test_reset();
        test_word_store();
        test_byte_half();
        test_wait_load();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_bus_bridge.md
Name: apb_bus_bridge

Overview:
Parametrised bus bridge between the RV32I core's data port and NUM_SLAVES APB4 peripherals. It replaces the direct core-to-RAM hookup in the MCU top with an address-decoded, wait-state-capable multi-slave fabric. The bridge adds a request/ready handshake, byte-lane strobe generation from the load/store size code, misalignment and unmapped-address errors, and a per-transfer timeout.

Parameters:
NUM_SLAVES, 4, number of APB slave channels (1..16)
BASE_ADDR, 32'h1000_0000, start of the peripheral window; must be 2^REGION_BITS aligned
REGION_BITS, 12, log2 of bytes per slave region; slave i covers BASE_ADDR + i*2^REGION_BITS
TIMEOUT, 16, maximum ACCESS cycles allowed without PREADY before the bridge aborts

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  core transfer request; held until ready
busWe  input  1  1 = store, 0 = load
busAddr  input  32  byte address
busWData  input  32  store data, right-aligned
strb  input  3  size code (funct3): x00 byte, x01 half, 010 word; 011 and 11x are invalid
busRData  output  32  raw read word, registered
ready  output  1  one-cycle completion pulse
err  output  1  qualifies ready; 1 = transfer failed
PADDR  output  REGION_BITS  offset within the selected region
PWDATA  output  32  lane-replicated write data
PWRITE  output  1  APB write
PSTRB  output  4  APB4 byte strobes
PSEL  output  NUM_SLAVES  one-hot slave select
PENABLE  output  1  APB access phase
PRDATA  input  NUM_SLAVES*32  slave read data; slave i uses bits [32i+31:32i]
PREADY  input  NUM_SLAVES  per-slave ready
PSLVERR  input  NUM_SLAVES  per-slave error

Behaviour:
- Reset (asynchronous, active-low): state goes to IDLE. busRData, ready, err, PADDR, PWDATA, PWRITE, PSTRB, PSEL and PENABLE all go to 0. The timeout counter clears. Reset mid-transfer drops PSEL and PENABLE immediately, and no ready pulse is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE: req is sampled only in this state.
  - Invalid, unmapped or misaligned request: go to RESP with err=1, busRData=0, and no PSEL ever asserted.
  - Valid request: latch the APB outputs, set PSEL[idx]=1, go to SETUP.
- Decode:
  - Mapped when BASE_ADDR <= busAddr < BASE_ADDR + NUM_SLAVES<<REGION_BITS.
  - idx = (busAddr - BASE_ADDR) >> REGION_BITS.
  - PADDR = busAddr[REGION_BITS-1:0].
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- Strobes and write data (stores):
  - byte: PSTRB = 1<<addr[1:0], PWDATA = {4{wdata[7:0]}}.
  - half: PSTRB = addr[1] ? 1100 : 0011, PWDATA = {2{wdata[15:0]}}.
  - word: PSTRB = 1111, PWDATA = wdata.
  - Loads: PSTRB = 0000, PWDATA = 0.
- SETUP: PSEL held, PENABLE=0, lasts exactly one cycle, then ACCESS.
- ACCESS: PENABLE=1; the counter increments each cycle, starting at 1.
  - If PREADY[idx]=1: capture PRDATA slice into busRData (loads only; stores leave busRData=0) and err=PSLVERR[idx]. Drop PSEL and PENABLE, go to RESP.
  - If the counter reaches TIMEOUT with PREADY[idx]=0: abort. Drop PSEL and PENABLE, set err=1 and busRData=0, go to RESP.
  - PREADY and PSLVERR of unselected slaves are ignored.
- RESP: ready=1 for exactly one cycle; err and busRData are valid. Next state is IDLE, with ready, err and busRData returning to 0.
  - A new req is accepted no earlier than the cycle after RESP.
- Latency with a zero-wait slave: req sampled at edge N → SETUP N+1 → ACCESS N+2 → ready N+3. Each slave wait cycle adds one cycle.
- Error latency: ready+err at edge N+1.
- APB outputs are stable from SETUP through the final ACCESS cycle, regardless of core-side input changes.
- Deasserting req after acceptance has no effect; the transfer completes.

Test Plan:
- Word store: busAddr 0x1000_1008, data 0xDEADBEEF, slave 1 PREADY=1 → PSEL=0010, PADDR=0x008, PSTRB=1111, PENABLE in cycle 2, ready in cycle 3 with err=0.
- Byte store: addr 0x1000_0003, wdata 0x000000A5 → PSTRB=1000, PWDATA=0xA5A5A5A5. Half store at 0x1000_0002 → PSTRB=1100.
- Load with 3 wait states: slave 2 returns PRDATA 0x12345678 → PENABLE high 4 cycles, ready at cycle 6, busRData=0x12345678.
- Errors:
  - Unmapped addr 0x2000_0000 → ready+err at cycle 1, PSEL never set.
  - Word load at 0x1000_0002 → same response.
  - PSLVERR=1 with PREADY=1 → err=1.
- Timeout: slave 0 holds PREADY=0 → after 16 ACCESS cycles PSEL and PENABLE drop; ready=1, err=1, busRData=0. A following request to slave 0 proceeds normally.
- Reset asserted in ACCESS → all outputs 0 immediately, no ready pulse. After release, a load completes with standard 3-cycle latency.
